// File: rtl/decimal_entry_pkg.sv
// decimal_entry_pkg: shared state encoding, limits and BCD segment decoder for the decimal keypad front end.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DIGIT_MAX  = 9;
    localparam int DEF_DIGITS = 3;
    localparam int DEF_OUT_W  = 10;

    // Active-high segments, bit order gfedcba; non-BCD codes are blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3f;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5b;
            4'd3:    return 7'h4f;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6d;
            4'd6:    return 7'h7d;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7f;
            4'd9:    return 7'h6f;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/decimal_entry_edge_sync.sv
// edge_sync: 2-flop synchronizer followed by a rising-edge detector giving a one-cycle pulse per press.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sr <= '0;
        else
            sr <= {sr[1:0], btn};
    end

    // sr[1] is the synchronized level, sr[2] its previous value.
    assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/decimal_entry.sv
// decimal_entry: collects up to DIGITS BCD digits and converts them to binary by repeated x10-and-add.
// Optional 7-segment echo outputs are enabled with `define DECIMAL_ENTRY_DISPLAY_EN.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             enter,
    input  logic             commit,
    input  logic             clear,
    output logic [OUT_W-1:0] value,
    output logic             valid,
    output logic [1:0]       count,
`ifdef DECIMAL_ENTRY_DISPLAY_EN
    output logic [6:0]       disp_unit,
    output logic [6:0]       disp_tens,
    output logic [6:0]       disp_hundreth,
`endif
    output logic             err
);

    localparam int SW = DIGITS * 4;

    logic             enter_p, commit_p, clear_p;
    state_t           state, state_nxt;
    logic [SW-1:0]    store, base_store;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [1:0]       idx, base_cnt;
    logic             in_entry, in_done, do_commit, do_enter, accept, last;

    edge_sync u_enter  (.clk(clk), .rst(rst), .btn(enter),  .pulse(enter_p));
    edge_sync u_commit (.clk(clk), .rst(rst), .btn(commit), .pulse(commit_p));
    edge_sync u_clear  (.clk(clk), .rst(rst), .btn(clear),  .pulse(clear_p));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = clear_p                ? IDLE    :
                    do_commit              ? CONVERT :
                    last                   ? DONE    :
                    accept                 ? ENTER   :
                    (do_enter && in_done)  ? IDLE    : state;
    end

    // A press in DONE starts a fresh entry, so it sees an empty store and zero count.
    always_comb begin
        in_entry   = state == IDLE || state == ENTER;
        in_done    = state == DONE;
        do_commit  = commit_p && !clear_p && in_entry;
        do_enter   = enter_p && !commit_p && !clear_p && (in_entry || in_done);
        base_cnt   = in_done ? 2'd0 : count;
        base_store = in_done ? '0 : store;
        accept     = do_enter && digit_in <= 4'(DIGIT_MAX) && base_cnt != 2'(DIGITS);
        last       = state == CONVERT && idx == 2'd0;
        acc_nxt    = (acc << 3) + (acc << 1) + OUT_W'(store[int'(idx) * 4 +: 4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store <= '0;
            count <= '0;
            err   <= 1'b0;
            acc   <= '0;
            idx   <= '0;
            value <= '0;
            valid <= 1'b0;
        end else if (clear_p) begin
            store <= '0;
            count <= '0;
            err   <= 1'b0;
            acc   <= '0;
            idx   <= '0;
            value <= '0;
            valid <= 1'b0;
        end else begin
            if (do_commit) begin
                acc <= '0;
                idx <= 2'(DIGITS - 1);
            end else if (state == CONVERT) begin
                acc <= acc_nxt;
                idx <= idx - 2'd1;
                if (idx == 2'd0) begin
                    value <= acc_nxt;
                    valid <= 1'b1;
                end
            end
            if (do_enter) begin
                valid <= 1'b0;
                store <= accept ? (base_store << 4) | SW'(digit_in) : base_store;
                count <= accept ? base_cnt + 2'd1 : base_cnt;
                err   <= err | !accept;
            end
        end
    end

`ifdef DECIMAL_ENTRY_DISPLAY_EN
    // The store is left intact by conversion, so in DONE it still holds the digits of value.
    logic [11:0] shown;

    always_comb begin
        shown         = 12'(store);
        disp_unit     = state == IDLE ? 7'd0 : seg7(shown[3:0]);
        disp_tens     = state == IDLE || DIGITS < 2 ? 7'd0 : seg7(shown[7:4]);
        disp_hundreth = state == IDLE || DIGITS < 3 ? 7'd0 : seg7(shown[11:8]);
    end
`endif

endmodule

// File: tb/tb_decimal_entry.sv
// tb_decimal_entry: random and directed keypad stimulus checked every cycle against a positional-value model.
module tb_decimal_entry;

    localparam int D = 3;
    localparam int W = 10;

    logic         clk = 0;
    logic         rst = 0;
    logic         enter = 0;
    logic         commit = 0;
    logic         clear = 0;
    logic [3:0]   digit_in = 0;
    logic [W-1:0] value;
    logic         valid;
    logic [1:0]   count;
    logic         err;

    int checks = 0;
    int errors = 0;

    int m_dig [D];
    int m_cnt, m_err, m_val, m_valid, m_mode, m_left, m_res;
    bit [2:0] he, hc, hx;

    decimal_entry #(.DIGITS(D), .OUT_W(W)) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .commit(commit),
        .clear(clear), .value(value), .valid(valid), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_dig   = '{default: 0};
        m_cnt   = 0;
        m_err   = 0;
        m_val   = 0;
        m_valid = 0;
        m_mode  = 0;
        m_left  = 0;
        he      = 0;
        hc      = 0;
        hx      = 0;
    endtask

    // Modes: 0 empty, 1 entering, 2 converting, 3 result held.
    task automatic m_step(input bit pe, input bit pc, input bit px);
        if (px) begin
            m_dig   = '{default: 0};
            m_cnt   = 0;
            m_err   = 0;
            m_val   = 0;
            m_valid = 0;
            m_mode  = 0;
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_val   = m_res;
                m_valid = 1;
                m_mode  = 3;
            end
        end else if (pc) begin
            if (m_mode != 3) begin
                m_res = 0;
                for (int i = 0; i < D; i++) m_res += m_dig[i] * (10 ** i);
                m_mode = 2;
                m_left = D;
            end
        end else if (pe) begin
            if (m_mode == 3) begin
                m_valid = 0;
                m_dig   = '{default: 0};
                m_cnt   = 0;
                m_mode  = 0;
            end
            if (digit_in > 9 || m_cnt == D) m_err = 1;
            else begin
                for (int i = D - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = int'(digit_in);
                m_cnt++;
                m_mode = 1;
            end
        end
    endtask

    // A button level seen at edge k acts on the design at edge k+2.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) m_reset();
        else begin
            m_step(he[1] & ~he[2], hc[1] & ~hc[2], hx[1] & ~hx[2]);
            he = {he[1:0], enter};
            hc = {hc[1:0], commit};
            hx = {hx[1:0], clear};
        end
    end

    initial forever begin
        @(negedge clk);
        chk("value", int'(value), m_val);
        chk("valid", int'(valid), m_valid);
        chk("count", int'(count), m_cnt);
        chk("err",   int'(err),   m_err);
    end

    task automatic press(input bit e, input bit c, input bit x, input logic [3:0] d,
                         input int hi, input int lo);
        digit_in = d;
        enter    = e;
        commit   = c;
        clear    = x;
        repeat (hi) @(negedge clk);
        enter  = 0;
        commit = 0;
        clear  = 0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        logic [3:0] d;
        int r, hi, lo;
        repeat (3) @(negedge clk);
        chk("rst_value", int'(value), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_err",   int'(err),   0);
        #2 rst = 1;
        @(negedge clk);

        press(1, 0, 0, 4'd4, 2, 6);
        chk("cnt_after_4", int'(count), 1);
        press(1, 0, 0, 4'd2, 2, 6);
        chk("cnt_after_2", int'(count), 2);
        press(1, 0, 0, 4'd7, 2, 6);
        chk("cnt_after_7", int'(count), 3);
        chk("model_cnt_3", m_cnt, 3);
        commit = 1;
        @(negedge clk);
        commit = 0;
        repeat (4) @(negedge clk);
        chk("valid_before_t4", int'(valid), 0);
        @(negedge clk);
        chk("valid_at_t4", int'(valid), 1);
        chk("value_427", int'(value), 427);
        chk("model_427", m_val, 427);
        chk("err_427", int'(err), 0);
        repeat (3) @(negedge clk);

        press(0, 0, 1, 4'd0, 2, 6);
        press(1, 0, 0, 4'hA, 2, 6);
        chk("err_bad_digit", int'(err), 1);
        chk("cnt_bad_digit", int'(count), 0);
        press(1, 0, 0, 4'd5, 2, 6);
        press(0, 1, 0, 4'd5, 2, 6);
        chk("value_5", int'(value), 5);
        chk("model_5", m_val, 5);

        press(0, 0, 1, 4'd0, 2, 6);
        for (int i = 0; i < 3; i++) press(1, 0, 0, 4'd9, 2, 6);
        chk("err_before_4th", int'(err), 0);
        press(1, 0, 0, 4'd9, 2, 6);
        chk("err_4th_digit", int'(err), 1);
        chk("cnt_saturated", int'(count), 3);
        press(0, 1, 0, 4'd9, 2, 6);
        chk("value_999", int'(value), 999);
        chk("model_999", m_val, 999);

        press(1, 0, 0, 4'd1, 2, 6);
        chk("done_enter_valid", int'(valid), 0);
        chk("done_enter_value", int'(value), 999);
        chk("done_enter_cnt", int'(count), 1);
        commit = 1;
        @(negedge clk);
        commit = 0;
        clear  = 1;
        @(negedge clk);
        clear = 0;
        @(negedge clk);
        chk("mid_convert_cnt", int'(count), 1);
        @(negedge clk);
        chk("clr_conv_value", int'(value), 0);
        chk("clr_conv_valid", int'(valid), 0);
        chk("clr_conv_count", int'(count), 0);
        chk("clr_conv_err",   int'(err),   0);
        repeat (4) @(negedge clk);
        chk("clr_conv_no_result", int'(valid), 0);

        press(1, 1, 0, 4'd5, 2, 8);
        chk("enter_commit_cnt", int'(count), 0);
        chk("enter_commit_valid", int'(valid), 1);
        chk("enter_commit_value", int'(value), 0);

        press(0, 0, 1, 4'd0, 2, 6);
        press(0, 1, 0, 4'd0, 2, 8);
        chk("empty_commit_valid", int'(valid), 1);
        chk("empty_commit_value", int'(value), 0);

        press(0, 0, 1, 4'd0, 2, 6);
        press(1, 0, 0, 4'd8, 2, 6);
        press(0, 1, 0, 4'd0, 2, 8);
        press(1, 0, 0, 4'd1, 2, 6);
        press(1, 0, 0, 4'd2, 2, 6);
        chk("pre_reset_cnt", int'(count), 2);
        chk("pre_reset_value", int'(value), 8);
        #2 rst = 0;
        #1;
        chk("async_value", int'(value), 0);
        chk("async_valid", int'(valid), 0);
        chk("async_count", int'(count), 0);
        chk("async_err",   int'(err),   0);
        @(negedge clk);
        #2 rst = 1;
        @(negedge clk);
        press(1, 0, 0, 4'd3, 2, 6);
        press(0, 1, 0, 4'd0, 2, 8);
        chk("post_reset_value", int'(value), 3);
        chk("post_reset_valid", int'(valid), 1);

        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            d  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 8);
            if (r < 50) press(1, 0, 0, d, hi, lo);
            else if (r < 70) press(0, 1, 0, d, hi, lo);
            else if (r < 78) press(0, 0, 1, d, hi, lo);
            else if (r < 86) press(1, 1, 0, d, hi, lo);
            else if (r < 90) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, d, hi, lo);
            else if (r < 94) begin
                #2 rst = 0;
                @(negedge clk);
                #3 rst = 1;
                @(negedge clk);
            end else repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
